tmss_multi_lock: RTL and testbench

//  Parametrised successor of the TMSS security gate on the 68k bus: NUM_CH key registers,
//  one per lockable channel, each unlocked by a 32-bit word-pair write matching its key.

---
 rtl/tmss_pkg.sv | 53 +++++
 rtl/tmss_key_slot.sv | 66 ++++++
 rtl/tmss_multi_lock.sv | 213 +++++++++++++++++++++
 tb/tb_tmss_multi_lock.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmss_pkg.sv
// ----------------------------------------------------------------------------
// tmss_pkg
//   Shared definitions for the multi-channel TMSS security gate:
//     - bus_state_e : bus handshake FSM states (IDLE, WAIT, ACK)
//     - dec_t       : result of own-register address decode
//     - DEF_*       : default key and address constants
//     - reg_decode(): maps a word address onto key-hi/key-lo/bank registers
// ----------------------------------------------------------------------------
package tmss_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic       hit;   // address is one of our registers
        logic       bank;  // bank-select register
        logic       key;   // one of the key registers
        logic       lo;    // key-lo half (else key-hi)
        logic [2:0] ch;    // channel index of the key register
    } dec_t;

    localparam logic [31:0] DEF_KEY       = 32'h5345_4741;  // "SEGA"
    localparam logic [22:0] DEF_KEY_ADDR  = 23'h50A000;
    localparam logic [22:0] DEF_BANK_ADDR = 23'h50A080;
    localparam logic [22:0] DEF_PROT_MASK = 23'h7F0000;
    localparam logic [22:0] DEF_PROT_BASE = 23'h600000;

    // Key registers are laid out as hi/lo word pairs starting at key_addr,
    // so the offset's LSB selects the half and the remaining bits the channel.
    function automatic dec_t reg_decode(input logic [31:0] va,
                                        input logic [31:0] key_addr,
                                        input logic [31:0] bank_addr,
                                        input logic [3:0]  num_ch);
        dec_t        d;
        logic [31:0] off;
        d   = '0;
        off = va - key_addr;
        if (va == bank_addr) begin
            d.hit  = 1'b1;
            d.bank = 1'b1;
        end else if ((va >= key_addr) && (off < {27'b0, num_ch, 1'b0})) begin
            d.hit = 1'b1;
            d.key = 1'b1;
            d.lo  = off[0];
            d.ch  = off[3:1];
        end
        return d;
    endfunction

endpackage

// File: rtl/tmss_key_slot.sv
// ----------------------------------------------------------------------------
// tmss_key_slot
//   One lockable channel: key-hi latch, key-lo register, key compare,
//   unlock flag and protected-region address compare.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     clr_i           soft clear of the unlock flag
//     wr_hi_i         commit a key-hi word write
//     wr_lo_i         commit a key-lo word write (evaluates the key)
//     wdata_i         write data
//     va_i            current bus word address
//     hi_o, lo_o      stored key halves for readback
//     ch_en_o         1 = channel unlocked
//     region_hit_o    va_i lies inside this channel's protected region
// ----------------------------------------------------------------------------
module tmss_key_slot
    import tmss_pkg::*;
#(
    parameter int             AW        = 23,
    parameter logic [31:0]    KEY       = DEF_KEY,
    parameter logic [AW-1:0]  PROT_MASK = AW'(DEF_PROT_MASK),
    parameter logic [AW-1:0]  PROT_BASE = AW'(DEF_PROT_BASE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr_hi_i,
    input  logic          wr_lo_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] va_i,
    output logic [15:0]   hi_o,
    output logic [15:0]   lo_o,
    output logic          ch_en_o,
    output logic          region_hit_o
);

    logic [15:0] hi_q, lo_q;
    logic        en_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q <= '0;
            lo_q <= '0;
            en_q <= 1'b0;
        end else begin
            if (wr_hi_i) begin
                hi_q <= wdata_i;
            end
            if (wr_lo_i) begin
                lo_q <= wdata_i;
            end
            // A wrong key re-locks the channel; soft clear wins over a write.
            if (clr_i) begin
                en_q <= 1'b0;
            end else if (wr_lo_i) begin
                en_q <= ({hi_q, wdata_i} == KEY);
            end
        end
    end

    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign ch_en_o      = en_q;
    assign region_hit_o = ((va_i & PROT_MASK) == PROT_BASE);

endmodule

// File: rtl/tmss_multi_lock.sv
// ----------------------------------------------------------------------------
// tmss_multi_lock
//   Multi-channel TMSS security gate on the 68k bus. Holds NUM_CH key slots,
//   the boot-ROM/cartridge bank select, the DTACK handshake for its own
//   registers and the sticky lockup detector.
//   Optional feature macro: TMSS_LOCKUP_RESET_EN -- when defined, a lockup
//   raises RESET for 16 MCLK and then soft-clears lockup, ch_en and bank.
//   Ports:
//     MCLK, SRES_n        clock, asynchronous active-low reset
//     VA, VD_i            word address, write data
//     VD_o, data_out_en   read data and its bus-drive enable
//     AS, UDS, LDS, RW    68k strobes (active low), RW=1 read
//     CE0_i               decoded ROM-space enable (active low)
//     CE0_o, BOOT_CE      cartridge / boot ROM enables (active low)
//     DTACK               acknowledge for own registers (active low)
//     ch_en               per-channel unlock flags
//     lockup              sticky protection violation flag
//     RESET               system reset request (active high)
// ----------------------------------------------------------------------------
module tmss_multi_lock
    import tmss_pkg::*;
#(
    parameter int                     NUM_CH    = 1,
    parameter int                     AW        = 23,
    parameter logic [AW-1:0]          KEY_ADDR  = AW'(DEF_KEY_ADDR),
    parameter logic [AW-1:0]          BANK_ADDR = AW'(DEF_BANK_ADDR),
    parameter logic [NUM_CH*32-1:0]   KEYS      = (NUM_CH*32)'(DEF_KEY),
    parameter logic [AW-1:0]          PROT_MASK = AW'(DEF_PROT_MASK),
    parameter logic [NUM_CH*AW-1:0]   PROT_BASE = (NUM_CH*AW)'(DEF_PROT_BASE),
    parameter int                     WAIT_CYC  = 1
) (
    input  logic              MCLK,
    input  logic              SRES_n,
    input  logic [AW-1:0]     VA,
    input  logic [15:0]       VD_i,
    output logic [15:0]       VD_o,
    output logic              data_out_en,
    input  logic              AS,
    input  logic              UDS,
    input  logic              LDS,
    input  logic              RW,
    input  logic              CE0_i,
    output logic              CE0_o,
    output logic              BOOT_CE,
    output logic              DTACK,
    output logic [NUM_CH-1:0] ch_en,
    output logic              lockup,
    output logic              RESET
);

    localparam logic [3:0] WC_LAST = 4'(WAIT_CYC - 1);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        bank_q, lockup_q;
    logic        commit, soft_clr, lockup_set;
    dec_t        dec;

    logic [15:0]       slot_hi [NUM_CH];
    logic [15:0]       slot_lo [NUM_CH];
    logic [NUM_CH-1:0] region_hit;
    logic [15:0]       rdata;

    assign dec = reg_decode(32'(VA), 32'(KEY_ADDR), 32'(BANK_ADDR), 4'(NUM_CH));

    // ---------------- bus FSM: state register ----------------
    always_ff @(posedge MCLK or negedge SRES_n) begin
        if (!SRES_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- bus FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!AS && dec.hit) begin
                    state_d = (WAIT_CYC == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (AS) begin
                    state_d = IDLE;           // aborted access, nothing commits
                end else if (cnt_q == WC_LAST) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK: begin
                if (AS) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- bus FSM: outputs ----------------
    always_comb begin
        // Register updates happen only on the edge that enters ACK.
        commit      = (state_q != ACK) && (state_d == ACK);
        DTACK       = !((state_q == ACK) && !AS);
        data_out_en = (state_q != IDLE) && RW && !AS;
        VD_o        = data_out_en ? rdata : 16'h0000;
    end

    // Read mux over the currently addressed register.
    always_comb begin
        rdata = 16'h0000;
        if (dec.bank) begin
            rdata = {15'b0, bank_q};
        end else if (dec.key) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (dec.ch == 3'(i)) begin
                    rdata = dec.lo ? slot_lo[i] : slot_hi[i];
                end
            end
        end
    end

    // Key slots; byte writes to key registers are acknowledged but ignored.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        logic sel;
        assign sel = commit && !RW && dec.key && (dec.ch == 3'(g)) && !UDS && !LDS;

        tmss_key_slot #(
            .AW        (AW),
            .KEY       (KEYS[32*g +: 32]),
            .PROT_MASK (PROT_MASK),
            .PROT_BASE (PROT_BASE[AW*g +: AW])
        ) u_slot (
            .clk_i        (MCLK),
            .rst_ni       (SRES_n),
            .clr_i        (soft_clr),
            .wr_hi_i      (sel && !dec.lo),
            .wr_lo_i      (sel && dec.lo),
            .wdata_i      (VD_i),
            .va_i         (VA),
            .hi_o         (slot_hi[g]),
            .lo_o         (slot_lo[g]),
            .ch_en_o      (ch_en[g]),
            .region_hit_o (region_hit[g])
        );
    end

    // Bank select.
    always_ff @(posedge MCLK or negedge SRES_n) begin
        if (!SRES_n) begin
            bank_q <= 1'b0;
        end else if (soft_clr) begin
            bank_q <= 1'b0;
        end else if (commit && !RW && dec.bank && !LDS) begin
            bank_q <= VD_i[0];
        end
    end

    assign BOOT_CE = bank_q ? 1'b1 : CE0_i;
    assign CE0_o   = bank_q ? CE0_i : 1'b1;

    // Protection: any access into a locked channel's region. No DTACK is
    // produced because these addresses never decode as our registers.
    assign lockup_set = !AS && |(region_hit & ~ch_en);

    always_ff @(posedge MCLK or negedge SRES_n) begin
        if (!SRES_n) begin
            lockup_q <= 1'b0;
        end else if (soft_clr) begin
            lockup_q <= 1'b0;
        end else if (lockup_set) begin
            lockup_q <= 1'b1;
        end
    end

    assign lockup = lockup_q;

`ifdef TMSS_LOCKUP_RESET_EN
    logic       rst_act_q;
    logic [3:0] rst_cnt_q;

    // 16-cycle reset pulse; the final cycle also soft-clears the gate.
    always_ff @(posedge MCLK or negedge SRES_n) begin
        if (!SRES_n) begin
            rst_act_q <= 1'b0;
            rst_cnt_q <= '0;
        end else if (!rst_act_q) begin
            if (lockup_set && !lockup_q) begin
                rst_act_q <= 1'b1;
                rst_cnt_q <= '0;
            end
        end else begin
            if (rst_cnt_q == 4'd15) begin
                rst_act_q <= 1'b0;
            end
            rst_cnt_q <= rst_cnt_q + 4'd1;
        end
    end

    assign soft_clr = rst_act_q && (rst_cnt_q == 4'd15);
    assign RESET    = rst_act_q;
`else
    assign soft_clr = 1'b0;
    assign RESET    = 1'b0;
`endif

endmodule

// File: tb/tb_tmss_multi_lock.sv
module tb_tmss_multi_lock;

    localparam int NCH = 2;
    localparam int WC  = 3;

    logic          MCLK = 1'b0;
    logic          SRES_n;
    logic [22:0]   VA;
    logic [15:0]   VD_i;
    logic [15:0]   VD_o;
    logic          data_out_en;
    logic          AS, UDS, LDS, RW;
    logic          CE0_i;
    logic          CE0_o, BOOT_CE, DTACK;
    logic [NCH-1:0] ch_en;
    logic          lockup, RESET;

    int n_checks = 0;
    int n_err    = 0;

    always #5 MCLK = ~MCLK;

    tmss_multi_lock #(
        .NUM_CH    (NCH),
        .AW        (23),
        .KEY_ADDR  (23'h50A000),
        .BANK_ADDR (23'h50A080),
        .KEYS      ({32'h1234_5678, 32'h5345_4741}),
        .PROT_MASK (23'h7F0000),
        .PROT_BASE ({23'h610000, 23'h600000}),
        .WAIT_CYC  (WC)
    ) dut (
        .MCLK        (MCLK),
        .SRES_n      (SRES_n),
        .VA          (VA),
        .VD_i        (VD_i),
        .VD_o        (VD_o),
        .data_out_en (data_out_en),
        .AS          (AS),
        .UDS         (UDS),
        .LDS         (LDS),
        .RW          (RW),
        .CE0_i       (CE0_i),
        .CE0_o       (CE0_o),
        .BOOT_CE     (BOOT_CE),
        .DTACK       (DTACK),
        .ch_en       (ch_en),
        .lockup      (lockup),
        .RESET       (RESET)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; reports cycles to DTACK (0 = no DTACK within bound),
    // read data, drive enable and ch_en as seen in the acknowledge cycle.
    task automatic bus_acc(input logic wr, input logic [22:0] a, input logic [15:0] d,
                           input logic uds, input logic lds,
                           output int cyc, output logic [15:0] rd,
                           output logic oe, output logic [NCH-1:0] chen);
        @(negedge MCLK);
        VA = a; VD_i = d; RW = ~wr; UDS = uds; LDS = lds; AS = 1'b0;
        cyc = 0; rd = '0; oe = 1'b0; chen = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge MCLK); #1;
            if (DTACK == 1'b0) begin
                cyc = n; rd = VD_o; oe = data_out_en; chen = ch_en;
                break;
            end
        end
        @(negedge MCLK);
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
        @(posedge MCLK); #1;
    endtask

    int              cyc;
    logic [15:0]     rd;
    logic            oe;
    logic [NCH-1:0]  chen;
    logic            dt_low;
    int              nrst;

    initial begin
        SRES_n = 1'b0; VA = '0; VD_i = '0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        RW = 1'b1; CE0_i = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_dtack", 32'(DTACK), 32'h1);
        chk("rst_chen", 32'(ch_en), 32'h0);
        chk("rst_lockup", 32'(lockup), 32'h0);
        chk("rst_reset", 32'(RESET), 32'h0);
        chk("rst_oe", 32'(data_out_en), 32'h0);
        chk("rst_vdo", 32'(VD_o), 32'h0);
        chk("rst_boot_ce", 32'(BOOT_CE), 32'h0);
        chk("rst_ce0_o", 32'(CE0_o), 32'h1);
        @(negedge MCLK); SRES_n = 1'b1;

        // Unlock channel 0 with "SEGA".
        bus_acc(1'b1, 23'h50A000, 16'h5345, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("hi_wr_cycles", 32'(cyc), 32'(WC + 1));
        chk("hi_wr_chen", 32'(chen), 32'h0);
        chk("dtack_release", 32'(DTACK), 32'h1);
        bus_acc(1'b1, 23'h50A001, 16'h4741, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("lo_wr_cycles", 32'(cyc), 32'(WC + 1));
        chk("unlock_ch0", 32'(chen), 32'h1);

        // Readback while unlocked.
        bus_acc(1'b0, 23'h50A000, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("rd_hi", 32'(rd), 32'h5345);
        chk("rd_oe", 32'(oe), 32'h1);
        chk("oe_after_as", 32'(data_out_en), 32'h0);

        // Wrong lo re-locks.
        bus_acc(1'b1, 23'h50A001, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("relock_ch0", 32'(chen), 32'h0);
        bus_acc(1'b0, 23'h50A000, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("rd_hi_after_relock", 32'(rd), 32'h5345);
        bus_acc(1'b0, 23'h50A001, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("rd_lo_after_relock", 32'(rd), 32'h0000);

        // Byte write to key-hi: acked, ignored.
        bus_acc(1'b1, 23'h50A000, 16'h1111, 1'b1, 1'b0, cyc, rd, oe, chen);
        chk("byte_wr_cycles", 32'(cyc), 32'(WC + 1));
        bus_acc(1'b0, 23'h50A000, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("byte_wr_hi_kept", 32'(rd), 32'h5345);

        // Unlock channel 1 with its own key.
        bus_acc(1'b1, 23'h50A002, 16'h1234, 1'b0, 1'b0, cyc, rd, oe, chen);
        bus_acc(1'b1, 23'h50A003, 16'h5678, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("unlock_ch1", 32'(chen), 32'h2);

        // Bank select to cartridge.
        bus_acc(1'b1, 23'h50A080, 16'h0001, 1'b1, 1'b0, cyc, rd, oe, chen);
        CE0_i = 1'b0; #1;
        chk("bank1_ce0_lo", 32'(CE0_o), 32'h0);
        chk("bank1_boot_ce", 32'(BOOT_CE), 32'h1);
        CE0_i = 1'b1; #1;
        chk("bank1_ce0_hi", 32'(CE0_o), 32'h1);
        bus_acc(1'b0, 23'h50A080, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("rd_bank", 32'(rd), 32'h0001);

        // Abort during WAIT: no DTACK, no update.
        @(negedge MCLK);
        VA = 23'h50A000; VD_i = 16'hAAAA; RW = 1'b0; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
        dt_low = 1'b0;
        repeat (2) begin @(posedge MCLK); #1; if (DTACK == 1'b0) dt_low = 1'b1; end
        @(negedge MCLK); AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
        repeat (3) begin @(posedge MCLK); #1; if (DTACK == 1'b0) dt_low = 1'b1; end
        chk("abort_no_dtack", 32'(dt_low), 32'h0);
        bus_acc(1'b0, 23'h50A000, 16'h0000, 1'b0, 1'b0, cyc, rd, oe, chen);
        chk("abort_hi_kept", 32'(rd), 32'h5345);
        chk("abort_cycles", 32'(cyc), 32'(WC + 1));

        // Unlocked channel 1 region: no lockup.
        @(negedge MCLK); VA = 23'h610010; AS = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        chk("unlocked_region_lockup", 32'(lockup), 32'h0);
        @(negedge MCLK); AS = 1'b1;

        // Locked channel 0 region: lockup.
        @(negedge MCLK); VA = 23'h600000; AS = 1'b0;
        @(posedge MCLK); #1;
        chk("lockup_set", 32'(lockup), 32'h1);
        chk("lockup_dtack", 32'(DTACK), 32'h1);
`ifdef TMSS_LOCKUP_RESET_EN
        nrst = (RESET == 1'b1) ? 1 : 0;
        @(negedge MCLK); AS = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge MCLK); #1;
            if (RESET == 1'b1) nrst++;
            else break;
        end
        chk("reset_pulse_len", 32'(nrst), 32'd16);
        chk("lockup_cleared", 32'(lockup), 32'h0);
        chk("chen_cleared", 32'(ch_en), 32'h0);
        chk("bank_cleared", 32'(CE0_o), 32'h1);
`else
        nrst = 0;
        @(negedge MCLK); AS = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge MCLK); #1;
            if (RESET == 1'b1) nrst++;
        end
        chk("reset_tied_low", 32'(nrst), 32'd0);
        chk("lockup_sticky", 32'(lockup), 32'h1);
`endif

        // Asynchronous reset in the middle of an acknowledged access.
        @(negedge MCLK);
        VA = 23'h50A000; RW = 1'b1; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge MCLK); #1;
            if (DTACK == 1'b0) begin cyc = n; break; end
        end
        chk("pre_async_ack", 32'(cyc), 32'(WC + 1));
        #2 SRES_n = 1'b0; #1;
        chk("async_dtack", 32'(DTACK), 32'h1);
        chk("async_lockup", 32'(lockup), 32'h0);
        chk("async_chen", 32'(ch_en), 32'h0);
        @(negedge MCLK); AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        SRES_n = 1'b1;
        repeat (2) @(posedge MCLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
